// File: rtl/lsu_align_if.sv
// Request/response and data-memory signal bundle for lsu_align.
// The slave modport is the alignment unit; the master modport is the core/memory side.
interface lsu_align_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
           mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
           mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: lane-shifts stores, extracts and extends loads,
// and splits memory-word-crossing accesses into two beats.
module lsu_align #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  lsu_align_if.slave bus
);
  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  state_e            state_q;
  logic [OFFW-1:0]   off_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd0_q;

  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [NB-1:0]     mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;

  int unsigned       req_off, req_len, q_off, q_len;
  logic              req_cross, req_bad, q_cross, sgn;
  logic [NB-1:0]     req_be, be1;
  logic [DATA_W-1:0] req_wdata_sh, wdata1, b0, b1, raw, ext;
  logic [ADDR_W-1:0] req_base;

  always_comb begin
    req_off      = 32'(bus.req_addr[OFFW-1:0]);
    req_len      = 32'd1 << bus.req_size;
    req_cross    = (req_off + req_len) > NB;
    req_bad      = (req_cross && !ALLOW_MISALIGN) || ((bus.req_size == 2'd3) && (DATA_W == 32));
    req_wdata_sh = bus.req_wdata << (8 * req_off);
    req_base     = bus.req_addr;
    req_base[OFFW-1:0] = '0;
    q_off   = 32'(off_q);
    q_len   = 32'd1 << size_q;
    q_cross = (q_off + q_len) > NB;
    wdata1  = wdata_q >> (8 * (NB - q_off));
    req_be  = '0;
    be1     = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      req_be[i] = (i >= req_off) && (i < req_off + req_len);
      be1[i]    = i < (q_off + q_len - NB);
    end
    // One shifter serves both cases: a single-beat load never reaches into b1.
    b0  = (state_q == BEAT1) ? rd0_q : bus.mem_rdata;
    b1  = (state_q == BEAT1) ? bus.mem_rdata : '0;
    raw = DATA_W'({b1, b0} >> (8 * q_off));
    sgn = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i == q_len - 1) sgn = raw[8*i+7];
    end
    ext = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      ext[8*i +: 8] = (i < q_len) ? raw[8*i +: 8] : {8{sgn & ~uns_q}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      rd0_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          off_q       <= bus.req_addr[OFFW-1:0];
          size_q      <= bus.req_size;
          we_q        <= bus.req_we;
          uns_q       <= bus.req_unsigned;
          wdata_q     <= bus.req_wdata;
          req_ready_q <= 1'b0;
          if (req_bad) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            state_q     <= BEAT0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.req_we;
            mem_addr_q  <= req_base;
            mem_be_q    <= req_be;
            mem_wdata_q <= req_wdata_sh;
          end
        end
        BEAT0, BEAT1: if (bus.mem_ack) begin
          rd0_q <= bus.mem_rdata;
          if (state_q == BEAT0 && q_cross) begin
            state_q     <= BEAT1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(NB);
            mem_be_q    <= be1;
            mem_wdata_q <= wdata1;
          end else begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : ext;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a misalign-splitting unit (ifa) and a
// misalign-rejecting unit (ifb), both 32-bit data / 32-bit address.
module tb_lsu_align;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lsu_align_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
  lsu_align_if #(.DATA_W(32), .ADDR_W(32)) ifb ();

  lsu_align #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  lsu_align #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
    ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_addr = addr;
    ifa.req_size = size; ifa.req_unsigned = uns; ifa.req_wdata = wdata;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifa.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", ifa.req_ready); end
    checks++; if (ifa.rsp_valid !== 1'b0 || ifa.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %b%b exp 00", ifa.rsp_valid, ifa.rsp_err); end
    checks++; if (ifa.mem_req !== 1'b0 || ifa.mem_we !== 1'b0 || ifa.mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem: got req=%b we=%b be=%b exp 0", ifa.mem_req, ifa.mem_we, ifa.mem_be); end
    checks++; if (ifa.mem_addr !== 32'h0 || ifa.mem_wdata !== 32'h0 || ifa.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_data: got %h %h %h exp 0", ifa.mem_addr, ifa.mem_wdata, ifa.rsp_rdata); end
    checks++; if (ifb.req_ready !== 1'b1 || ifb.mem_req !== 1'b0) begin errors++; $display("FAIL rst_b: got ready=%b req=%b exp 1 0", ifb.req_ready, ifb.mem_req); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_load(input logic uns, input logic [31:0] exp_data);
    checks++; if (ifa.req_ready !== 1'b1) begin errors++; $display("FAIL bl_ready: got %b exp 1", ifa.req_ready); end
    issue_a(1'b0, 32'h103, 2'd0, uns, 32'h0);
    checks++; if (ifa.mem_req !== 1'b1 || ifa.mem_we !== 1'b0) begin errors++; $display("FAIL bl_req: got req=%b we=%b exp 1 0", ifa.mem_req, ifa.mem_we); end
    checks++; if (ifa.mem_addr !== 32'h100) begin errors++; $display("FAIL bl_addr: got %h exp 00000100", ifa.mem_addr); end
    checks++; if (ifa.mem_be !== 4'b1000) begin errors++; $display("FAIL bl_be: got %b exp 1000", ifa.mem_be); end
    checks++; if (ifa.req_ready !== 1'b0 || ifa.rsp_valid !== 1'b0) begin errors++; $display("FAIL bl_busy: got ready=%b vld=%b exp 0 0", ifa.req_ready, ifa.rsp_valid); end
    ifa.mem_ack = 1'b1; ifa.mem_rdata = 32'h80FF1234;
    @(posedge clk); #1;
    ifa.mem_ack = 1'b0;
    checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_err !== 1'b0) begin errors++; $display("FAIL bl_vld: got vld=%b err=%b exp 1 0", ifa.rsp_valid, ifa.rsp_err); end
    checks++; if (ifa.rsp_rdata !== exp_data) begin errors++; $display("FAIL bl_data: got %h exp %h", ifa.rsp_rdata, exp_data); end
    checks++; if (ifa.mem_req !== 1'b0 || ifa.req_ready !== 1'b0) begin errors++; $display("FAIL bl_resp: got req=%b ready=%b exp 0 0", ifa.mem_req, ifa.req_ready); end
    @(posedge clk); #1;
    checks++; if (ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b1) begin errors++; $display("FAIL bl_idle: got vld=%b ready=%b exp 0 1", ifa.rsp_valid, ifa.req_ready); end
  endtask

  task automatic test_split_load(input logic [31:0] addr, input logic [31:0] a0, input logic [3:0] be0,
                                 input logic [31:0] d0, input logic [31:0] a1, input logic [3:0] be1,
                                 input logic [31:0] d1, input logic [1:0] size, input logic [31:0] exp_data);
    issue_a(1'b0, addr, size, 1'b0, 32'h0);
    checks++; if (ifa.mem_addr !== a0 || ifa.mem_be !== be0) begin errors++; $display("FAIL sl_beat0: got %h/%b exp %h/%b", ifa.mem_addr, ifa.mem_be, a0, be0); end
    ifa.mem_ack = 1'b1; ifa.mem_rdata = d0;
    @(posedge clk); #1;
    ifa.mem_ack = 1'b0;
    checks++; if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== a1 || ifa.mem_be !== be1) begin errors++; $display("FAIL sl_beat1: got req=%b %h/%b exp 1 %h/%b", ifa.mem_req, ifa.mem_addr, ifa.mem_be, a1, be1); end
    checks++; if (ifa.rsp_valid !== 1'b0) begin errors++; $display("FAIL sl_early: got %b exp 0", ifa.rsp_valid); end
    ifa.mem_ack = 1'b1; ifa.mem_rdata = d1;
    @(posedge clk); #1;
    ifa.mem_ack = 1'b0;
    checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== exp_data) begin errors++; $display("FAIL sl_data: got vld=%b %h exp 1 %h", ifa.rsp_valid, ifa.rsp_rdata, exp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_split_store;
    issue_a(1'b1, 32'h101, 2'd2, 1'b0, 32'hDDCCBBAA);
    checks++; if (ifa.mem_we !== 1'b1 || ifa.mem_addr !== 32'h100 || ifa.mem_be !== 4'b1110) begin errors++; $display("FAIL ss_beat0: got we=%b %h/%b exp 1 00000100/1110", ifa.mem_we, ifa.mem_addr, ifa.mem_be); end
    checks++; if (ifa.mem_wdata !== 32'hCCBBAA00) begin errors++; $display("FAIL ss_wd0: got %h exp ccbbaa00", ifa.mem_wdata); end
    ifa.mem_ack = 1'b1; ifa.mem_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    ifa.mem_ack = 1'b0;
    checks++; if (ifa.mem_we !== 1'b1 || ifa.mem_addr !== 32'h104 || ifa.mem_be !== 4'b0001) begin errors++; $display("FAIL ss_beat1: got we=%b %h/%b exp 1 00000104/0001", ifa.mem_we, ifa.mem_addr, ifa.mem_be); end
    checks++; if (ifa.mem_wdata !== 32'h000000DD) begin errors++; $display("FAIL ss_wd1: got %h exp 000000dd", ifa.mem_wdata); end
    ifa.mem_ack = 1'b1;
    @(posedge clk); #1;
    ifa.mem_ack = 1'b0;
    checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_err !== 1'b0 || ifa.rsp_rdata !== 32'h0) begin errors++; $display("FAIL ss_rsp: got vld=%b err=%b %h exp 1 0 00000000", ifa.rsp_valid, ifa.rsp_err, ifa.rsp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states;
    issue_a(1'b1, 32'h102, 2'd1, 1'b0, 32'h00001234);
    ifa.req_we = 1'b0; ifa.req_addr = 32'h200; ifa.req_size = 2'd0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ifa.mem_req !== 1'b1 || ifa.mem_we !== 1'b1 || ifa.mem_addr !== 32'h100 || ifa.mem_be !== 4'b1100 || ifa.mem_wdata !== 32'h12340000) begin errors++; $display("FAIL ws_hold%0d: got req=%b we=%b %h/%b/%h exp 1 1 00000100/1100/12340000", k, ifa.mem_req, ifa.mem_we, ifa.mem_addr, ifa.mem_be, ifa.mem_wdata); end
      checks++; if (ifa.req_ready !== 1'b0 || ifa.rsp_valid !== 1'b0) begin errors++; $display("FAIL ws_busy%0d: got ready=%b vld=%b exp 0 0", k, ifa.req_ready, ifa.rsp_valid); end
      ifa.req_valid = (k % 2 == 0);
      ifa.mem_ack = (k == 3);
      @(posedge clk); #1;
    end
    ifa.mem_ack = 1'b0;
    ifa.req_valid = 1'b1;
    checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== 32'h0 || ifa.req_ready !== 1'b0) begin errors++; $display("FAIL ws_rsp: got vld=%b %h ready=%b exp 1 00000000 0", ifa.rsp_valid, ifa.rsp_rdata, ifa.req_ready); end
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    checks++; if (ifa.mem_req !== 1'b0 || ifa.req_ready !== 1'b1 || ifa.rsp_valid !== 1'b0) begin errors++; $display("FAIL ws_noaccept: got req=%b ready=%b vld=%b exp 0 1 0", ifa.mem_req, ifa.req_ready, ifa.rsp_valid); end
  endtask

  task automatic test_errors;
    ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_addr = 32'h102;
    ifb.req_size = 2'd2; ifb.req_unsigned = 1'b0; ifb.req_wdata = 32'h0;
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
    checks++; if (ifb.rsp_valid !== 1'b1 || ifb.rsp_err !== 1'b1 || ifb.rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_mis: got vld=%b err=%b %h exp 1 1 00000000", ifb.rsp_valid, ifb.rsp_err, ifb.rsp_rdata); end
    checks++; if (ifb.mem_req !== 1'b0) begin errors++; $display("FAIL err_mis_req: got %b exp 0", ifb.mem_req); end
    @(posedge clk); #1;
    checks++; if (ifb.rsp_valid !== 1'b0 || ifb.mem_req !== 1'b0 || ifb.req_ready !== 1'b1) begin errors++; $display("FAIL err_mis_idle: got vld=%b req=%b ready=%b exp 0 0 1", ifb.rsp_valid, ifb.mem_req, ifb.req_ready); end
    ifb.req_valid = 1'b1; ifb.req_addr = 32'h100;
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
    checks++; if (ifb.mem_req !== 1'b1 || ifb.mem_be !== 4'b1111 || ifb.rsp_valid !== 1'b0) begin errors++; $display("FAIL err_aligned: got req=%b be=%b vld=%b exp 1 1111 0", ifb.mem_req, ifb.mem_be, ifb.rsp_valid); end
    ifb.mem_ack = 1'b1; ifb.mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    ifb.mem_ack = 1'b0;
    checks++; if (ifb.rsp_valid !== 1'b1 || ifb.rsp_err !== 1'b0 || ifb.rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL err_aligned_rsp: got vld=%b err=%b %h exp 1 0 cafef00d", ifb.rsp_valid, ifb.rsp_err, ifb.rsp_rdata); end
    @(posedge clk); #1;
    issue_a(1'b0, 32'h100, 2'd3, 1'b0, 32'h0);
    checks++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_err !== 1'b1 || ifa.mem_req !== 1'b0) begin errors++; $display("FAIL err_dword: got vld=%b err=%b req=%b exp 1 1 0", ifa.rsp_valid, ifa.rsp_err, ifa.mem_req); end
    @(posedge clk); #1;
    checks++; if (ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b1) begin errors++; $display("FAIL err_dword_idle: got vld=%b ready=%b exp 0 1", ifa.rsp_valid, ifa.req_ready); end
  endtask

  task automatic test_reset_midflight;
    issue_a(1'b1, 32'h103, 2'd1, 1'b0, 32'h0000BEEF);
    ifa.mem_ack = 1'b1;
    @(posedge clk); #1;
    ifa.mem_ack = 1'b0;
    checks++; if (ifa.mem_addr !== 32'h104 || ifa.mem_be !== 4'b0001) begin errors++; $display("FAIL rm_beat1: got %h/%b exp 00000104/0001", ifa.mem_addr, ifa.mem_be); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (ifa.mem_req !== 1'b0 || ifa.mem_we !== 1'b0 || ifa.mem_be !== 4'h0 || ifa.mem_addr !== 32'h0 || ifa.mem_wdata !== 32'h0) begin errors++; $display("FAIL rm_mem: got req=%b we=%b %h/%b/%h exp all 0", ifa.mem_req, ifa.mem_we, ifa.mem_addr, ifa.mem_be, ifa.mem_wdata); end
    checks++; if (ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b1 || ifa.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rm_rsp: got vld=%b ready=%b %h exp 0 1 0", ifa.rsp_valid, ifa.req_ready, ifa.rsp_rdata); end
    @(posedge clk); #1;
    checks++; if (ifa.rsp_valid !== 1'b0 || ifa.mem_req !== 1'b0) begin errors++; $display("FAIL rm_after: got vld=%b req=%b exp 0 0", ifa.rsp_valid, ifa.mem_req); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0; ifa.req_size = '0;
    ifa.req_unsigned = 1'b0; ifa.req_wdata = '0; ifa.mem_ack = 1'b0; ifa.mem_rdata = '0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0; ifb.req_size = '0;
    ifb.req_unsigned = 1'b0; ifb.req_wdata = '0; ifb.mem_ack = 1'b0; ifb.mem_rdata = '0;
    test_reset();
    test_byte_load(1'b0, 32'hFFFFFF80);
    test_byte_load(1'b1, 32'h00000080);
    test_split_load(32'h103, 32'h100, 4'b1000, 32'hAB000000,
                    32'h104, 4'b0001, 32'h000000CD, 2'd1, 32'hFFFFCDAB);
    test_split_store();
    test_wait_states();
    test_errors();
    test_reset_midflight();
    test_split_load(32'hFFFFFFFE, 32'hFFFFFFFC, 4'b1100, 32'hBBAA0000,
                    32'h00000000, 4'b0011, 32'h0000DDCC, 2'd2, 32'hDDCCBBAA);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
